// File: rtl/multi_hs_seq.sv
// N-channel handshake sequencer: round-robin grant onto one shared engine, WAIT timeout, bounded retry.
// Define MULTI_HS_SEQ_ASSERT_EN to compile in SVA over the handshake outputs.
module multi_hs_seq #(
  parameter int NCH       = 4,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_i,
  input  logic           eng_done_i,
  input  logic           eng_err_i,
  output logic [NCH-1:0] rdy_o,
  output logic [NCH-1:0] start_o,
  output logic [NCH-1:0] rt_o,
  output logic [NCH-1:0] er_o,
  output logic [NCH-1:0] endd_o,
  output logic           busy_o
);

  localparam int CW = $clog2(NCH);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RCNT_MAX  = RW'(MAX_RETRY);
  localparam logic [CW-1:0] CHAN_LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t         r_state, w_state_nx;
  logic [CW-1:0]  r_chan, w_chan_nx;
  logic [CW-1:0]  r_ptr, w_ptr_nx;
  logic [CW-1:0]  w_gnt;
  logic           w_gnt_vld;
  logic [TW-1:0]  r_tmr, w_tmr_nx;
  logic [RW-1:0]  r_rcnt, w_rcnt_nx;
  logic           r_ok, w_ok_nx;
  logic           r_rt, w_rt_nx;
  logic           w_fail;
  logic [NCH-1:0] w_onehot;

  // Scan from highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_i[(int'(r_ptr) + i) % NCH]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = CW'((int'(r_ptr) + i) % NCH);
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_chan_nx  = r_chan;
    w_ptr_nx   = r_ptr;
    w_tmr_nx   = r_tmr;
    w_rcnt_nx  = r_rcnt;
    w_ok_nx    = r_ok;
    w_rt_nx    = r_rt;
    // Error beats done; a timeout only counts if done did not arrive in the last cycle.
    w_fail     = eng_err_i || ((r_tmr == TMR_LAST) && !eng_done_i);
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_chan_nx  = w_gnt;
          w_rcnt_nx  = '0;
          w_rt_nx    = 1'b0;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        w_tmr_nx   = '0;
        w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (w_fail) begin
          if (r_rcnt < RCNT_MAX) begin
            w_rcnt_nx  = r_rcnt + 1'b1;
            w_rt_nx    = 1'b1;
            w_state_nx = S_START;
          end else begin
            w_ok_nx    = 1'b0;
            w_state_nx = S_DONE;
          end
        end else if (eng_done_i) begin
          w_ok_nx    = 1'b1;
          w_state_nx = S_DONE;
        end else begin
          w_tmr_nx = r_tmr + 1'b1;
        end
      end
      S_DONE: begin
        w_ptr_nx   = (r_chan == CHAN_LAST) ? '0 : r_chan + 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_chan  <= '0;
      r_ptr   <= '0;
      r_tmr   <= '0;
      r_rcnt  <= '0;
      r_ok    <= 1'b0;
      r_rt    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_chan  <= w_chan_nx;
      r_ptr   <= w_ptr_nx;
      r_tmr   <= w_tmr_nx;
      r_rcnt  <= w_rcnt_nx;
      r_ok    <= w_ok_nx;
      r_rt    <= w_rt_nx;
    end
  end

  always_comb begin
    w_onehot         = '0;
    w_onehot[r_chan] = 1'b1;
  end

  // Outputs depend only on registered state.
  always_comb begin
    busy_o  = (r_state != S_IDLE);
    rdy_o   = busy_o ? ~w_onehot : '1;
    start_o = (r_state == S_START) ? w_onehot : '0;
    rt_o    = ((r_state == S_START) && r_rt) ? w_onehot : '0;
    endd_o  = ((r_state == S_DONE) && r_ok) ? w_onehot : '0;
    er_o    = ((r_state == S_DONE) && !r_ok) ? w_onehot : '0;
  end

`ifdef MULTI_HS_SEQ_ASSERT_EN
  a_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({start_o, endd_o, er_o}));

  for (genvar c = 0; c < NCH; c++) begin : g_sva
    a_rt_start: assert property (@(posedge clk) disable iff (rst)
      rt_o[c] |-> start_o[c]);
    a_attempt: assert property (@(posedge clk) disable iff (rst)
      start_o[c] |-> (!rdy_o[c] && !endd_o[c] && !er_o[c])
        ##1 (!rdy_o[c] && !endd_o[c] && !er_o[c]) [*1:TIMEOUT]
        ##1 (rt_o[c] || endd_o[c] || er_o[c]));
    a_bounded: assert property (@(posedge clk) disable iff (rst)
      start_o[c] |-> ##[1:TIMEOUT+1] (rt_o[c] || endd_o[c] || er_o[c] || !busy_o));
  end
`endif

endmodule

// File: tb/tb_multi_hs_seq.sv
// Bench for multi_hs_seq: per-transaction schedule model (grant, attempts, outcome) vs every output each cycle.
module tb_multi_hs_seq;
  localparam int NCH       = 4;
  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] req_i;
  logic           eng_done_i, eng_err_i;
  logic [NCH-1:0] rdy_o, start_o, rt_o, er_o, endd_o;
  logic           busy_o;

  multi_hs_seq #(.NCH(NCH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .eng_done_i(eng_done_i), .eng_err_i(eng_err_i),
    .rdy_o(rdy_o), .start_o(start_o), .rt_o(rt_o), .er_o(er_o), .endd_o(endd_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0, m_ptr = 0;
  int n_rt = 0, n_er = 0, n_endd = 0;
  int first_start_cyc = 0, term_cyc = 0;
  // Attempt plan: kind 0=done, 1=err, 2=err+done together, 3=no response; k = WAIT index of the event
  int p_kind[MAX_RETRY+1];
  int p_k[MAX_RETRY+1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected {rdy, start, rt, er, endd, busy} for a channel g in a given phase.
  function automatic logic [31:0] ev(input int g, input bit bsy, input bit st, input bit rt,
                                     input bit er, input bit en);
    logic [NCH-1:0] oh;
    logic [NCH-1:0] z;
    oh = '0;
    z  = '0;
    if (bsy) oh[g] = 1'b1;
    return 32'({~oh, st ? oh : z, rt ? oh : z, er ? oh : z, en ? oh : z, bsy});
  endfunction

  function automatic int oh2i(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic step(input logic [NCH-1:0] rq, input logic dn, input logic er, input logic rs,
                      input string tag, input logic [31:0] exp);
    @(negedge clk);
    cyc++;
    req_i = rq; eng_done_i = dn; eng_err_i = er; rst = rs;
    chk(tag, 32'({rdy_o, start_o, rt_o, er_o, endd_o, busy_o}), exp);
    if (|rt_o)   n_rt++;
    if (|er_o)   n_er++;
    if (|endd_o) n_endd++;
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b0, 1'b1, "reset_hold", ev(0, 0, 0, 0, 0, 0));
    step('0, 1'b0, 1'b0, 1'b1, "reset_state", ev(0, 0, 0, 0, 0, 0));
    m_ptr = 0;
  endtask

  // One IDLE cycle offering rq; if granted, runs the planned attempts through DONE.
  task automatic txn(input logic [NCH-1:0] rq, input bit hold, output int og);
    int g, kk;
    bit ok;
    logic [NCH-1:0] nrq;
    logic dn, er;
    og = -1;
    g  = -1;
    ok = 1'b0;
    step(rq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "idle", ev(0, 0, 0, 0, 0, 0));
    if (rq == '0) return;
    for (int i = 0; i < NCH; i++)
      if (g < 0 && rq[(m_ptr + i) % NCH]) g = (m_ptr + i) % NCH;
    for (int a = 0; a <= MAX_RETRY; a++) begin
      nrq = hold ? rq : NCH'($urandom);
      step(nrq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
           (a == 0) ? "start" : "retry_start", ev(g, 1, 1, a > 0, 0, 0));
      if (a == 0) begin
        og = oh2i(start_o);
        first_start_cyc = cyc;
      end
      kk = (p_kind[a] == 3) ? TIMEOUT - 1 : p_k[a];
      for (int j = 0; j <= kk; j++) begin
        dn = 1'b0; er = 1'b0;
        if (j == kk) begin
          case (p_kind[a])
            0:       dn = 1'b1;
            1:       begin er = 1'b1; dn = 1'($urandom_range(0, 1)); end
            2:       begin er = 1'b1; dn = 1'b1; end
            default: ;
          endcase
        end
        step(nrq, dn, er, 1'b0, "wait", ev(g, 1, 0, 0, 0, 0));
      end
      ok = (p_kind[a] == 0);
      if (ok) break;
    end
    step(hold ? rq : NCH'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
         "done", ev(g, 1, 0, 0, !ok, ok));
    term_cyc = cyc;
    m_ptr = (g + 1) % NCH;
  endtask

  task automatic plan(input int k0, input int k1, input int k2, input int t0, input int t1, input int t2);
    p_kind[0] = k0; p_kind[1] = k1; p_kind[2] = k2;
    p_k[0] = t0; p_k[1] = t1; p_k[2] = t2;
  endtask

  initial begin
    int og, prev;
    int rr_exp[5];
    rr_exp = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_i = '0; eng_done_i = 1'b0; eng_err_i = 1'b0;
    @(posedge clk);
    do_reset();

    // single request on channel 1, done on the third WAIT cycle
    plan(0, 0, 0, 2, 0, 0);
    txn(4'b0010, 1'b1, og);
    chk("t1_grant", og, 1);
    chk("t1_latency", term_cyc - first_start_cyc, 4);

    // all channels requesting: round-robin order and 4-cycle spacing
    do_reset();
    plan(0, 0, 0, 0, 0, 0);
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 1'b1, og);
      chk("rr_order", og, rr_exp[i]);
      if (i > 0) chk("rr_gap", first_start_cyc - prev, 4);
      prev = first_start_cyc;
    end

    // two errors then success
    n_rt = 0; n_er = 0; n_endd = 0;
    plan(1, 1, 0, 3, 0, 5);
    txn(4'b1000, 1'b1, og);
    chk("t3_rt", n_rt, 2);
    chk("t3_er", n_er, 0);
    chk("t3_endd", n_endd, 1);

    // no response at all: three timeouts then terminal error
    n_rt = 0; n_er = 0; n_endd = 0;
    plan(3, 3, 3, 0, 0, 0);
    txn(4'b0100, 1'b1, og);
    chk("t4_rt", n_rt, MAX_RETRY);
    chk("t4_er", n_er, 1);
    chk("t4_endd", n_endd, 0);
    chk("t4_latency", term_cyc - first_start_cyc, (MAX_RETRY + 1) * (TIMEOUT + 1));

    // done+err together counts as error; done in IDLE is ignored
    n_rt = 0; n_er = 0; n_endd = 0;
    plan(2, 0, 0, 1, 0, 0);
    txn(4'b0001, 1'b1, og);
    chk("t5_rt", n_rt, 1);
    chk("t5_endd", n_endd, 1);
    step('0, 1'b1, 1'b0, 1'b0, "t5_idle_done", ev(0, 0, 0, 0, 0, 0));
    step('0, 1'b0, 1'b0, 1'b0, "t5_idle_after", ev(0, 0, 0, 0, 0, 0));

    // reset during WAIT on channel 2, then pointer restarts at 0
    n_er = 0; n_endd = 0;
    step(4'b0100, 1'b0, 1'b0, 1'b0, "t6_idle", ev(0, 0, 0, 0, 0, 0));
    step('0, 1'b0, 1'b0, 1'b0, "t6_start", ev(2, 1, 1, 0, 0, 0));
    step('0, 1'b0, 1'b0, 1'b0, "t6_wait", ev(2, 1, 0, 0, 0, 0));
    step('0, 1'b0, 1'b0, 1'b1, "t6_wait_rst", ev(2, 1, 0, 0, 0, 0));
    m_ptr = 0;
    plan(0, 0, 0, 0, 0, 0);
    txn(4'b0101, 1'b1, og);
    chk("t6_grant", og, 0);
    chk("t6_endd", n_endd, 1);
    chk("t6_er", n_er, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int a = 0; a <= MAX_RETRY; a++) begin
        p_kind[a] = $urandom_range(0, 3);
        p_k[a]    = $urandom_range(0, TIMEOUT - 1);
      end
      txn(($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
          1'($urandom_range(0, 1)), og);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
